// File: rtl/ems_pkg.sv
// Shared constants for the EMS page mapper: register map, ID value and
// page-register field positions.
package ems_pkg;

  typedef enum logic [1:0] {
    REG_CTRL  = 2'd0,
    REG_INDEX = 2'd1,
    REG_DATA  = 2'd2,
    REG_ID    = 2'd3
  } ems_reg_e;

  localparam logic [15:0] EMS_ID = 16'h454D;

  localparam int CTRL_EN_BIT  = 0;
  localparam int PG_VALID_BIT = 15;
  localparam int PG_NUM_LSB   = 0;

endpackage

// File: rtl/ems_xlate.sv
// Registered address translation: maps CPU word addresses falling in the
// frame window onto SDRAM pages, passing everything else straight through.
module ems_xlate
  import ems_pkg::*;
#(
  parameter int          NUM_PAGES  = 4,
  parameter int          PAGE_W     = 8,
  parameter logic [3:0]  FRAME_SEG  = 4'hD,
  parameter logic [29:0] EMS_BASE_W = 30'h0008_0000
) (
  input  logic                        wb_clk,
  input  logic                        wb_rst_n,
  input  logic                        en,
  input  logic [NUM_PAGES-1:0]        page_vld,
  input  logic [NUM_PAGES*PAGE_W-1:0] page_num,
  input  logic [19:1]                 sdram_adr_i,
  input  logic                        sdram_stb_i,
  output logic [31:0]                 sdram_adr_o,
  output logic                        sdram_stb_o
);

  localparam int SLOT_W = $clog2(NUM_PAGES);
  localparam int OFF_W  = 15 - SLOT_W;

  logic [SLOT_W-1:0] slot_p0;
  logic [OFF_W-1:0]  off_p0;
  logic [PAGE_W-1:0] pg_p0;
  logic              hit_p0;
  logic [29:0]       word_p0;

  logic [31:0]       adr_p1;
  logic              vld_p1;

  // Stage p0: window decode and page lookup
  always_comb begin
    slot_p0 = sdram_adr_i[15 -: SLOT_W];
    off_p0  = sdram_adr_i[OFF_W:1];
    pg_p0   = page_num[slot_p0*PAGE_W +: PAGE_W];
    hit_p0  = en && (sdram_adr_i[19:16] == FRAME_SEG) && page_vld[slot_p0];
    word_p0 = {11'b0, sdram_adr_i};
    if (hit_p0)
      word_p0 = EMS_BASE_W + (30'(pg_p0) << OFF_W) + 30'(off_p0);
  end

  // Stage p1: registered byte address and strobe
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      vld_p1 <= 1'b0;
      adr_p1 <= '0;
    end else begin
      vld_p1 <= sdram_stb_i;
      adr_p1 <= {word_p0, 2'b00};
    end
  end

  assign sdram_adr_o = adr_p1;
  assign sdram_stb_o = vld_p1;

endmodule

// File: rtl/ems_mapper.sv
// EMS mapper top: Wishbone register file (CTRL/INDEX/DATA/ID) feeding the
// translation datapath. Define EMS_AUTOINC_EN to auto-increment INDEX on DATA writes.
module ems_mapper
  import ems_pkg::*;
#(
  parameter int          NUM_PAGES  = 4,
  parameter int          PAGE_W     = 8,
  parameter logic [3:0]  FRAME_SEG  = 4'hD,
  parameter logic [29:0] EMS_BASE_W = 30'h0008_0000
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic [2:1]  wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  input  logic [19:1] sdram_adr_i,
  input  logic        sdram_stb_i,
  output logic [31:0] sdram_adr_o,
  output logic        sdram_stb_o
);

  localparam int SLOT_W = $clog2(NUM_PAGES);

  logic                        en;
  logic [SLOT_W-1:0]           index;
  logic [NUM_PAGES-1:0]        page_vld;
  logic [NUM_PAGES*PAGE_W-1:0] page_num;

  logic        acc;
  logic [15:0] rd_data;
  logic [15:0] wr_data;

  // The ack feeds back so a held strobe gets one ack every other cycle.
  assign acc = wb_cyc_i & wb_stb_i & ~wb_ack_o;

  always_comb begin
    rd_data = '0;
    case (ems_reg_e'(wb_adr_i))
      REG_CTRL:  rd_data[CTRL_EN_BIT] = en;
      REG_INDEX: rd_data[SLOT_W-1:0] = index;
      REG_DATA: begin
        rd_data[PG_VALID_BIT]         = page_vld[index];
        rd_data[PG_NUM_LSB +: PAGE_W] = page_num[index*PAGE_W +: PAGE_W];
      end
      default:   rd_data = EMS_ID;
    endcase
  end

  // Unselected byte lanes keep the register's current contents.
  assign wr_data = {wb_sel_i[1] ? wb_dat_i[15:8] : rd_data[15:8],
                    wb_sel_i[0] ? wb_dat_i[7:0]  : rd_data[7:0]};

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      en       <= 1'b0;
      index    <= '0;
      page_vld <= '0;
      page_num <= '0;
    end else begin
      wb_ack_o <= acc;
      wb_dat_o <= acc ? rd_data : 16'h0000;
      if (acc && wb_we_i) begin
        case (ems_reg_e'(wb_adr_i))
          REG_CTRL:  en    <= wr_data[CTRL_EN_BIT];
          REG_INDEX: index <= wr_data[SLOT_W-1:0];
          REG_DATA: begin
            page_vld[index]                  <= wr_data[PG_VALID_BIT];
            page_num[index*PAGE_W +: PAGE_W] <= wr_data[PG_NUM_LSB +: PAGE_W];
`ifdef EMS_AUTOINC_EN
            index <= index + 1'b1;
`else
            index <= index;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  ems_xlate #(
    .NUM_PAGES  (NUM_PAGES),
    .PAGE_W     (PAGE_W),
    .FRAME_SEG  (FRAME_SEG),
    .EMS_BASE_W (EMS_BASE_W)
  ) u_xlate (
    .wb_clk      (wb_clk),
    .wb_rst_n    (wb_rst_n),
    .en          (en),
    .page_vld    (page_vld),
    .page_num    (page_num),
    .sdram_adr_i (sdram_adr_i),
    .sdram_stb_i (sdram_stb_i),
    .sdram_adr_o (sdram_adr_o),
    .sdram_stb_o (sdram_stb_o)
  );

endmodule

// File: tb/tb_ems_mapper.sv
// Self-checking bench for ems_mapper: two instances (frame D and frame F)
// share one bus and are checked against a behavioural page-map model.
module tb_ems_mapper;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic [2:1]  wb_adr_i = '0;
  logic [15:0] wb_dat_i = '0;
  logic [1:0]  wb_sel_i = '0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [19:1] sdram_adr_i = '0;
  logic        sdram_stb_i = 1'b0;

  logic [15:0] wb_dat_o, wb_dat_t;
  logic        wb_ack_o, wb_ack_t;
  logic [31:0] sdram_adr_o, sdram_adr_t;
  logic        sdram_stb_o, sdram_stb_t;

  int checks = 0;
  int errors = 0;

  bit m_en;
  int m_index;
  bit m_vld[4];
  int m_num[4];

  always #5 wb_clk = ~wb_clk;

  ems_mapper u_dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o), .sdram_adr_i(sdram_adr_i),
    .sdram_stb_i(sdram_stb_i), .sdram_adr_o(sdram_adr_o), .sdram_stb_o(sdram_stb_o)
  );

  ems_mapper #(.FRAME_SEG(4'hF)) u_top (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_t), .wb_sel_i(wb_sel_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_t), .sdram_adr_i(sdram_adr_i),
    .sdram_stb_i(sdram_stb_i), .sdram_adr_o(sdram_adr_t), .sdram_stb_o(sdram_stb_t)
  );

  // ---------------- reference model ----------------
  function automatic void model_clear();
    m_en = 1'b0;
    m_index = 0;
    for (int i = 0; i < 4; i++) begin
      m_vld[i] = 1'b0;
      m_num[i] = 0;
    end
  endfunction

  function automatic logic [15:0] model_read(input logic [1:0] r);
    logic [15:0] v;
    case (r)
      2'd0: v = {15'b0, m_en};
      2'd1: v = 16'(m_index);
      2'd2: v = {m_vld[m_index], 7'b0, 8'(m_num[m_index])};
      default: v = 16'h454D;
    endcase
    return v;
  endfunction

  function automatic void model_write(input logic [1:0] r, input logic [15:0] d,
                                      input logic [1:0] sel);
    logic [15:0] cur, m;
    cur = model_read(r);
    m = {sel[1] ? d[15:8] : cur[15:8], sel[0] ? d[7:0] : cur[7:0]};
    case (r)
      2'd0: m_en = m[0];
      2'd1: m_index = int'(m) % 4;
      2'd2: begin
        m_vld[m_index] = m[15];
        m_num[m_index] = int'(m[7:0]);
`ifdef EMS_AUTOINC_EN
        m_index = (m_index + 1) % 4;
`endif
      end
      default: ;
    endcase
  endfunction

  // Byte address expected for CPU word address a with the frame at segment seg.
  function automatic logic [31:0] model_xlate(input logic [3:0] seg, input logic [18:0] a);
    longint unsigned byte_adr, w;
    int s;
    bit hit;
    byte_adr = 64'(a) * 2;
    s = int'((byte_adr >> 14) % 4);
    hit = m_en && ((byte_adr >> 16) == 64'(seg)) && m_vld[s];
    if (hit) w = 64'h80000 + 64'(m_num[s]) * 8192 + (64'(a) % 8192);
    else     w = 64'(a);
    w = w % (64'd1 << 30);
    return 32'(w * 4);
  endfunction

  // ---------------- bus helpers ----------------
  task automatic wb_xfer(input logic [1:0] r, input logic [15:0] d, input logic [1:0] sel,
                         input logic we, output logic [15:0] q);
    int lat;
    lat = 0;
    q = '0;
    wb_adr_i = r; wb_dat_i = d; wb_sel_i = sel; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(posedge wb_clk); #1;
      if (wb_ack_o) begin
        lat = i;
        q = wb_dat_o;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL ack_latency reg=%0d got=%0d want=1", r, lat);
    end
    @(posedge wb_clk); #1;
  endtask

  task automatic reg_write(input logic [1:0] r, input logic [15:0] d, input logic [1:0] sel);
    logic [15:0] q;
    wb_xfer(r, d, sel, 1'b1, q);
    model_write(r, d, sel);
  endtask

  task automatic reg_read(input logic [1:0] r, output logic [15:0] q);
    wb_xfer(r, 16'h0000, 2'b11, 1'b0, q);
  endtask

  task automatic do_reset();
    wb_rst_n = 1'b0;
    repeat (2) @(posedge wb_clk);
    #1;
    wb_rst_n = 1'b1;
    model_clear();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] q;
    sdram_adr_i = 19'h12345;
    sdram_stb_i = 1'b1;
    do_reset();
    checks++;
    if (wb_ack_o !== 1'b0 || wb_dat_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_wb ack=%b dat=%h want ack=0 dat=0000", wb_ack_o, wb_dat_o);
    end
    checks++;
    if (sdram_stb_o !== 1'b0 || sdram_adr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_sdram stb=%b adr=%h want stb=0 adr=00000000", sdram_stb_o, sdram_adr_o);
    end
    sdram_stb_i = 1'b0;
    for (int r = 0; r < 3; r++) begin
      reg_read(2'(r), q);
      checks++;
      if (q !== model_read(2'(r))) begin
        errors++;
        $display("FAIL reset_reg%0d got=%h want=%h", r, q, model_read(2'(r)));
      end
    end
  endtask

  task automatic test_passthrough();
    logic [31:0] exp;
    sdram_adr_i = 19'h68000;
    sdram_stb_i = 1'b1;
    exp = model_xlate(4'hD, 19'h68000);
    @(posedge wb_clk); #1;
    checks++;
    if (sdram_adr_o !== exp || sdram_stb_o !== 1'b1) begin
      errors++;
      $display("FAIL passthrough adr=%h stb=%b want adr=%h stb=1", sdram_adr_o, sdram_stb_o, exp);
    end
    sdram_stb_i = 1'b0;
    @(posedge wb_clk); #1;
    checks++;
    if (sdram_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL stb_delay got=%b want=0", sdram_stb_o);
    end
  endtask

  task automatic test_map();
    logic [31:0] exp_d, exp_t;
    reg_write(2'd0, 16'h0001, 2'b11);
    reg_write(2'd1, 16'h0001, 2'b11);
    reg_write(2'd2, 16'h8003, 2'b11);
    sdram_adr_i = 19'h6A000;
    sdram_stb_i = 1'b1;
    exp_d = model_xlate(4'hD, 19'h6A000);
    exp_t = model_xlate(4'hF, 19'h6A000);
    @(posedge wb_clk); #1;
    checks++;
    if (sdram_adr_o !== exp_d) begin
      errors++;
      $display("FAIL map_slot1 got=%h want=%h", sdram_adr_o, exp_d);
    end
    checks++;
    if (sdram_adr_t !== exp_t) begin
      errors++;
      $display("FAIL map_other_frame got=%h want=%h", sdram_adr_t, exp_t);
    end
    sdram_stb_i = 1'b0;
  endtask

  task automatic test_id_ack();
    logic [15:0] q;
    logic        exp_ack;
    wb_adr_i = 2'd3; wb_we_i = 1'b0; wb_sel_i = 2'b11;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge wb_clk); #1;
      exp_ack = (k % 2 == 1);
      checks++;
      if (wb_ack_o !== exp_ack || wb_ack_t !== exp_ack) begin
        errors++;
        $display("FAIL held_ack cyc=%0d got=%b/%b want=%b", k + 1, wb_ack_o, wb_ack_t, exp_ack);
      end
      checks++;
      if (wb_dat_o !== (exp_ack ? 16'h454D : 16'h0000)) begin
        errors++;
        $display("FAIL held_dat cyc=%0d got=%h want=%h", k + 1, wb_dat_o,
                 exp_ack ? 16'h454D : 16'h0000);
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge wb_clk); #1;
    reg_write(2'd3, 16'h1234, 2'b11);
    reg_read(2'd3, q);
    checks++;
    if (q !== model_read(2'd3)) begin
      errors++;
      $display("FAIL id_after_write got=%h want=%h", q, model_read(2'd3));
    end
  endtask

  task automatic test_bytelanes();
    logic [15:0] q;
    reg_write(2'd1, 16'h0002, 2'b11);
    reg_write(2'd1, 16'h0000, 2'b10);
    reg_write(2'd2, 16'hFFAB, 2'b01);
    reg_write(2'd1, 16'h0002, 2'b11);
    reg_read(2'd2, q);
    checks++;
    if (q !== model_read(2'd2)) begin
      errors++;
      $display("FAIL lane_low got=%h want=%h", q, model_read(2'd2));
    end
    reg_write(2'd2, 16'h8000, 2'b10);
    reg_write(2'd1, 16'h0002, 2'b11);
    reg_read(2'd2, q);
    checks++;
    if (q !== model_read(2'd2)) begin
      errors++;
      $display("FAIL lane_high got=%h want=%h", q, model_read(2'd2));
    end
    reg_write(2'd0, 16'h0000, 2'b10);
    reg_read(2'd0, q);
    checks++;
    if (q !== model_read(2'd0)) begin
      errors++;
      $display("FAIL ctrl_lane got=%h want=%h", q, model_read(2'd0));
    end
  endtask

  task automatic test_autoinc();
    logic [15:0] q;
    reg_write(2'd1, 16'h0003, 2'b11);
    reg_write(2'd2, 16'h8011, 2'b11);
    reg_write(2'd2, 16'h8022, 2'b11);
    reg_read(2'd1, q);
    checks++;
    if (q !== model_read(2'd1)) begin
      errors++;
      $display("FAIL autoinc_index got=%h want=%h", q, model_read(2'd1));
    end
    for (int p = 0; p < 4; p += 3) begin
      reg_write(2'd1, 16'(p), 2'b11);
      reg_read(2'd2, q);
      checks++;
      if (q !== model_read(2'd2)) begin
        errors++;
        $display("FAIL autoinc_page%0d got=%h want=%h", p, q, model_read(2'd2));
      end
    end
  endtask

  task automatic test_top_frame();
    logic [31:0] exp_d, exp_t;
    reg_write(2'd0, 16'h0001, 2'b11);
    reg_write(2'd1, 16'h0003, 2'b11);
    reg_write(2'd2, 16'h80FF, 2'b11);
    reg_write(2'd1, 16'h0003, 2'b11);
    sdram_stb_i = 1'b1;
    sdram_adr_i = 19'h7FFFF;
    exp_d = model_xlate(4'hD, 19'h7FFFF);
    exp_t = model_xlate(4'hF, 19'h7FFFF);
    @(posedge wb_clk); #1;
    checks++;
    if (sdram_adr_t !== exp_t || sdram_adr_o !== exp_d) begin
      errors++;
      $display("FAIL top_frame got=%h/%h want=%h/%h", sdram_adr_t, sdram_adr_o, exp_t, exp_d);
    end
    sdram_adr_i = 19'h6FFFF;
    exp_d = model_xlate(4'hD, 19'h6FFFF);
    @(posedge wb_clk); #1;
    checks++;
    if (sdram_adr_o !== exp_d) begin
      errors++;
      $display("FAIL frame_end got=%h want=%h", sdram_adr_o, exp_d);
    end
    sdram_stb_i = 1'b0;
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_map, exp_pass;
    reg_write(2'd0, 16'h0001, 2'b11);
    reg_write(2'd1, 16'h0001, 2'b11);
    reg_write(2'd2, 16'h8005, 2'b11);
    reg_write(2'd1, 16'h0001, 2'b11);
    sdram_adr_i = 19'h6A123;
    sdram_stb_i = 1'b1;
    exp_map = model_xlate(4'hD, 19'h6A123);
    wb_adr_i = 2'd2; wb_dat_i = 16'h0000; wb_sel_i = 2'b11; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge wb_clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    checks++;
    if (wb_ack_o !== 1'b1 || sdram_adr_o !== exp_map) begin
      errors++;
      $display("FAIL same_cycle_map ack=%b adr=%h want ack=1 adr=%h", wb_ack_o, sdram_adr_o, exp_map);
    end
    model_write(2'd2, 16'h0000, 2'b11);
    exp_pass = model_xlate(4'hD, 19'h6A123);
    @(posedge wb_clk); #1;
    checks++;
    if (sdram_adr_o !== exp_pass) begin
      errors++;
      $display("FAIL after_invalidate got=%h want=%h", sdram_adr_o, exp_pass);
    end
    sdram_stb_i = 1'b0;
    @(posedge wb_clk); #1;
  endtask

  task automatic test_random();
    logic [15:0] d, q;
    logic [1:0]  r, sel;
    logic [3:0]  top;
    logic [18:0] a;
    logic [31:0] exp_d, exp_t;
    logic        stb;
    for (int it = 0; it < 40; it++) begin
      r = 2'($urandom_range(0, 3));
      d = 16'($urandom);
      if (r == 2'd0) d[0] = ($urandom_range(0, 3) != 0);
      sel = 2'($urandom_range(0, 3));
      reg_write(r, d, sel);
      if (it % 5 == 0) begin
        r = 2'($urandom_range(0, 3));
        reg_read(r, q);
        checks++;
        if (q !== model_read(r)) begin
          errors++;
          $display("FAIL rand_read reg=%0d got=%h want=%h", r, q, model_read(r));
        end
      end
      for (int c = 0; c < 4; c++) begin
        case ($urandom_range(0, 2))
          0: top = 4'hD;
          1: top = 4'hF;
          default: top = 4'($urandom);
        endcase
        a = {top, 15'($urandom)};
        stb = 1'($urandom);
        sdram_adr_i = a;
        sdram_stb_i = stb;
        exp_d = model_xlate(4'hD, a);
        exp_t = model_xlate(4'hF, a);
        @(posedge wb_clk); #1;
        checks++;
        if (sdram_adr_o !== exp_d || sdram_stb_o !== stb) begin
          errors++;
          $display("FAIL rand_xlate_d a=%h got=%h/%b want=%h/%b", a, sdram_adr_o, sdram_stb_o, exp_d, stb);
        end
        checks++;
        if (sdram_adr_t !== exp_t || sdram_stb_t !== stb) begin
          errors++;
          $display("FAIL rand_xlate_f a=%h got=%h/%b want=%h/%b", a, sdram_adr_t, sdram_stb_t, exp_t, stb);
        end
      end
      sdram_stb_i = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] q;
    logic [31:0] exp;
    reg_write(2'd0, 16'h0001, 2'b11);
    reg_write(2'd1, 16'h0002, 2'b11);
    reg_write(2'd2, 16'h8009, 2'b11);
    sdram_adr_i = 19'h6C010;
    sdram_stb_i = 1'b1;
    wb_adr_i = 2'd2; wb_dat_i = 16'h8077; wb_sel_i = 2'b11; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    wb_rst_n = 1'b0;
    @(posedge wb_clk); #1;
    checks++;
    if (wb_ack_o !== 1'b0 || wb_dat_o !== 16'h0 || sdram_stb_o !== 1'b0 || sdram_adr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid ack=%b dat=%h stb=%b adr=%h want all 0",
               wb_ack_o, wb_dat_o, sdram_stb_o, sdram_adr_o);
    end
    wb_rst_n = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    model_clear();
    exp = model_xlate(4'hD, 19'h6C010);
    @(posedge wb_clk); #1;
    checks++;
    if (sdram_adr_o !== exp || sdram_stb_o !== 1'b1 || wb_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_pass adr=%h stb=%b ack=%b want adr=%h stb=1 ack=0",
               sdram_adr_o, sdram_stb_o, wb_ack_o, exp);
    end
    sdram_stb_i = 1'b0;
    reg_write(2'd1, 16'h0002, 2'b11);
    reg_read(2'd2, q);
    checks++;
    if (q !== model_read(2'd2)) begin
      errors++;
      $display("FAIL reset_mid_page got=%h want=%h", q, model_read(2'd2));
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_passthrough();
    test_map();
    test_id_ack();
    test_bytelanes();
    test_autoinc();
    test_top_frame();
    test_same_cycle();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
